// File: rtl/iq_pkg.sv
// Shared types and constants for the integer issue queue.
package iq_pkg;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_TAG_W  = 6;
  localparam int IQ_DATA_W = 32;

  // RV32I integer opcodes routed to this queue
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Reference entry layout at the default widths
  typedef struct packed {
    logic [IQ_TAG_W-1:0]  rs1_tag;
    logic                 rs1_valid;
    logic [IQ_DATA_W-1:0] rs1_data;
    logic [IQ_TAG_W-1:0]  rs2_tag;
    logic                 rs2_valid;
    logic [IQ_DATA_W-1:0] rs2_data;
    logic [IQ_TAG_W-1:0]  rd_tag;
    logic [6:0]           opcode;
    logic [6:0]           funct7;
    logic [2:0]           funct3;
    logic                 imm;
    logic [31:0]          pc;
  } iq_entry_t;

endpackage

// File: rtl/iq_oldest_select.sv
// Priority picker: lowest-index (oldest) set bit of the ready vector.
module iq_oldest_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         ready,
  output logic [DEPTH-1:0]         onehot,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(DEPTH);

  // Scan from entry 0 upward; first ready entry wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready[i] && !any) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered, shift-collapsing, CDB-snooping.
// Optional feature macro: IQ_WAKEUP_BYPASS_EN (select sees same-cycle
// CDB wakeup and forwards cdb_data onto the issue operands).
module int_issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic              disp_rs1_valid,
  input  logic              disp_rs2_valid,
  input  logic [DATA_W-1:0] disp_rs1_data,
  input  logic [DATA_W-1:0] disp_rs2_data,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic [6:0]        disp_opcode,
  input  logic [6:0]        disp_funct7,
  input  logic [2:0]        disp_funct3,
  input  logic              disp_imm,
  input  logic [31:0]       disp_pc,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              queue_full,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [6:0]        issue_opcode,
  output logic [6:0]        issue_funct7,
  output logic [2:0]        issue_funct3,
  output logic              issue_imm,
  output logic [31:0]       issue_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Same layout as iq_entry_t, sized by this instance's parameters
  typedef struct packed {
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs1_valid;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rs2_valid;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rd_tag;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic              imm;
    logic [31:0]       pc;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           woke  [DEPTH];
  entry_t           nxt   [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic [CNT_W-1:0] count_nxt;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready;
  entry_t           sel_e;
  entry_t           disp_e;
  logic             fire;
  logic             do_disp;

  assign queue_full  = (count == CNT_W'(DEPTH));
  assign issue_valid = any_ready && !rst;
  assign fire        = issue_valid && issue_ready;
  assign do_disp     = disp_en && !queue_full;

  // Apply the current CDB broadcast to every stored waiting operand
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (cdb_valid && !q[i].rs1_valid && (q[i].rs1_tag == cdb_tag)) begin
        woke[i].rs1_valid = 1'b1;
        woke[i].rs1_data  = cdb_data;
      end
      if (cdb_valid && !q[i].rs2_valid && (q[i].rs2_tag == cdb_tag)) begin
        woke[i].rs2_valid = 1'b1;
        woke[i].rs2_data  = cdb_data;
      end
    end
  end

  // Ready vector over occupied entries
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
`ifdef IQ_WAKEUP_BYPASS_EN
        ready[i] = woke[i].rs1_valid && woke[i].rs2_valid;
`else
        ready[i] = q[i].rs1_valid && q[i].rs2_valid;
`endif
      end
    end
  end

  iq_oldest_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .ready  (ready),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (any_ready)
  );

  // Issue mux; woke equals q for any entry ready on registered bits,
  // so one source serves both build variants
  always_comb begin
    sel_e = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_onehot[i] && issue_valid) begin
        sel_e = woke[i];
      end
    end
  end

  assign issue_rs1_data = sel_e.rs1_data;
  assign issue_rs2_data = sel_e.rs2_data;
  assign issue_rd_tag   = sel_e.rd_tag;
  assign issue_opcode   = sel_e.opcode;
  assign issue_funct7   = sel_e.funct7;
  assign issue_funct3   = sel_e.funct3;
  assign issue_imm      = sel_e.imm;
  assign issue_pc       = sel_e.pc;

  // New entry, including capture of a same-cycle CDB broadcast
  always_comb begin
    disp_e           = '0;
    disp_e.rs1_tag   = disp_rs1_tag;
    disp_e.rs1_valid = disp_rs1_valid;
    disp_e.rs1_data  = disp_rs1_data;
    disp_e.rs2_tag   = disp_rs2_tag;
    disp_e.rs2_valid = disp_rs2_valid || disp_imm;
    disp_e.rs2_data  = disp_rs2_data;
    disp_e.rd_tag    = disp_rd_tag;
    disp_e.opcode    = disp_opcode;
    disp_e.funct7    = disp_funct7;
    disp_e.funct3    = disp_funct3;
    disp_e.imm       = disp_imm;
    disp_e.pc        = disp_pc;
    if (cdb_valid && !disp_e.rs1_valid && (disp_rs1_tag == cdb_tag)) begin
      disp_e.rs1_valid = 1'b1;
      disp_e.rs1_data  = cdb_data;
    end
    if (cdb_valid && !disp_e.rs2_valid && (disp_rs2_tag == cdb_tag)) begin
      disp_e.rs2_valid = 1'b1;
      disp_e.rs2_data  = cdb_data;
    end
  end

  // Next array: collapse over the issued slot, then append at the new tail.
  // Wakeup is applied before the shift so a moving entry keeps its capture.
  always_comb begin
    count_after = count - CNT_W'(fire);
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (fire && (IDX_W'(i) >= sel_idx)) begin
        nxt[i] = woke[i + 1];
      end else begin
        nxt[i] = woke[i];
      end
    end
    if (fire && (IDX_W'(DEPTH - 1) >= sel_idx)) begin
      nxt[DEPTH-1] = '0;
    end else begin
      nxt[DEPTH-1] = woke[DEPTH-1];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) >= count_after) begin
        nxt[i] = '0;
      end
      if (do_disp && (CNT_W'(i) == count_after)) begin
        nxt[i] = disp_e;
      end
    end
    count_nxt = count_after + CNT_W'(do_disp);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue (DEPTH=4, TAG_W=6, DATA_W=32).
module tb_int_issue_queue;
  import iq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_en;
  logic [TAG_W-1:0]  disp_rs1_tag, disp_rs2_tag;
  logic              disp_rs1_valid, disp_rs2_valid;
  logic [DATA_W-1:0] disp_rs1_data, disp_rs2_data;
  logic [TAG_W-1:0]  disp_rd_tag;
  logic [6:0]        disp_opcode, disp_funct7;
  logic [2:0]        disp_funct3;
  logic              disp_imm;
  logic [31:0]       disp_pc;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              queue_full, issue_valid, issue_ready;
  logic [DATA_W-1:0] issue_rs1_data, issue_rs2_data;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [6:0]        issue_opcode, issue_funct7;
  logic [2:0]        issue_funct3;
  logic              issue_imm;
  logic [31:0]       issue_pc;

  always #5 clk = ~clk;

  int_issue_queue #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .disp_en        (disp_en),
    .disp_rs1_tag   (disp_rs1_tag),
    .disp_rs2_tag   (disp_rs2_tag),
    .disp_rs1_valid (disp_rs1_valid),
    .disp_rs2_valid (disp_rs2_valid),
    .disp_rs1_data  (disp_rs1_data),
    .disp_rs2_data  (disp_rs2_data),
    .disp_rd_tag    (disp_rd_tag),
    .disp_opcode    (disp_opcode),
    .disp_funct7    (disp_funct7),
    .disp_funct3    (disp_funct3),
    .disp_imm       (disp_imm),
    .disp_pc        (disp_pc),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .queue_full     (queue_full),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .issue_rd_tag   (issue_rd_tag),
    .issue_opcode   (issue_opcode),
    .issue_funct7   (issue_funct7),
    .issue_funct3   (issue_funct3),
    .issue_imm      (issue_imm),
    .issue_pc       (issue_pc)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  rd;
    logic [6:0]  opc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc_of(input logic [5:0] rd);
    return 32'h1000 + {24'd0, rd, 2'b00};
  endfunction

  task automatic disp(input logic [5:0] t1, input logic v1, input logic [31:0] d1,
                      input logic [5:0] t2, input logic v2, input logic [31:0] d2,
                      input logic [5:0] rd, input logic imm);
    disp_en        = 1'b1;
    disp_rs1_tag   = t1;
    disp_rs1_valid = v1;
    disp_rs1_data  = d1;
    disp_rs2_tag   = t2;
    disp_rs2_valid = v2;
    disp_rs2_data  = d2;
    disp_rd_tag    = rd;
    disp_imm       = imm;
    disp_opcode    = imm ? OPC_OP_IMM : OPC_OP;
    disp_funct7    = 7'd0;
    disp_funct3    = 3'd0;
    disp_pc        = pc_of(rd);
  endtask

  task automatic expect_issue(input logic [31:0] r1, input logic [31:0] r2,
                              input logic [5:0] rd, input logic imm);
    exp_t e;
    e.rs1 = r1;
    e.rs2 = r2;
    e.rd  = rd;
    e.opc = imm ? OPC_OP_IMM : OPC_OP;
    e.pc  = pc_of(rd);
    sb.push_back(e);
  endtask

  // Compare every accepted issue against the oldest expectation
  always @(negedge clk) begin
    if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rs1", issue_rs1_data, e.rs1);
        chk("iss_rs2", issue_rs2_data, e.rs2);
        chk("iss_rd",  issue_rd_tag,   e.rd);
        chk("iss_opc", issue_opcode,   e.opc);
        chk("iss_pc",  issue_pc,       e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; disp_en = 1'b0; issue_ready = 1'b0;
    disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_valid = 1'b0; disp_rs2_valid = 1'b0;
    disp_rs1_data = '0; disp_rs2_data = '0; disp_rd_tag = '0; disp_opcode = '0;
    disp_funct7 = '0; disp_funct3 = '0; disp_imm = 1'b0; disp_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    step(); step();
    neg();
    chk("rst_valid", issue_valid, 0);
    chk("rst_full",  queue_full, 0);
    chk("rst_rs1",   issue_rs1_data, 0);
    chk("rst_rd",    issue_rd_tag, 0);
    step(); rst = 1'b0;

    // basic ready dispatch
    issue_ready = 1'b1;
    disp(6'd0, 1'b1, 32'd20, 6'd0, 1'b1, 32'd30, 6'd1, 1'b0);
    expect_issue(32'd20, 32'd30, 6'd1, 1'b0);
    neg(); chk("t1_before", issue_valid, 0);
    step(); disp_en = 1'b0;
    neg();
    chk("t1_valid", issue_valid, 1);
    chk("t1_rs1", issue_rs1_data, 20);
    chk("t1_rs2", issue_rs2_data, 30);
    step(); neg(); chk("t1_empty", issue_valid, 0);

    // CDB wakeup of a stored operand
    step();
    disp(6'd5, 1'b0, 32'd0, 6'd0, 1'b1, 32'd7, 6'd2, 1'b0);
    expect_issue(32'd126, 32'd7, 6'd2, 1'b0);
    step(); disp_en = 1'b0;
    neg(); chk("t2_wait0", issue_valid, 0);
    step(); neg(); chk("t2_wait1", issue_valid, 0);
    step(); cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'd126;
    neg(); chk("t2_same", issue_valid, BYP);
    step(); cdb_valid = 1'b0;
    neg(); chk("t2_next", issue_valid, !BYP);
    step(); neg(); chk("t2_empty", issue_valid, 0);

    // capture during the dispatch cycle
    step();
    disp(6'd3, 1'b0, 32'hdead, 6'd0, 1'b1, 32'd11, 6'd3, 1'b0);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'd90;
    expect_issue(32'd90, 32'd11, 6'd3, 1'b0);
    neg(); chk("t3_before", issue_valid, 0);
    step(); disp_en = 1'b0; cdb_valid = 1'b0;
    neg(); chk("t3_valid", issue_valid, 1); chk("t3_rs1", issue_rs1_data, 90);

    // immediate form: rs2 valid regardless of tag/valid
    step();
    disp(6'd0, 1'b1, 32'd8, 6'd9, 1'b0, 32'd77, 6'd4, 1'b1);
    expect_issue(32'd8, 32'd77, 6'd4, 1'b1);
    step(); disp_en = 1'b0;
    neg(); chk("t3_imm_valid", issue_valid, 1); chk("t3_imm_flag", issue_imm, 1);
    step(); neg(); chk("t3_empty", issue_valid, 0);

    // fill, overflow drop, issue+dispatch while full
    step(); issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6'd0, 1'b1, 32'(100 + i), 6'd0, 1'b1, 32'(200 + i), 6'(10 + i), 1'b0);
      expect_issue(32'(100 + i), 32'(200 + i), 6'(10 + i), 1'b0);
      step();
    end
    disp(6'd0, 1'b1, 32'd104, 6'd0, 1'b1, 32'd204, 6'd14, 1'b0);
    neg(); chk("t4_full", queue_full, 1);
    step();
    neg(); chk("t4_full_drop", queue_full, 1);
    step(); issue_ready = 1'b1;
    neg(); chk("t4_full_issue", queue_full, 1);
    step(); issue_ready = 1'b0; disp_en = 1'b0;
    neg(); chk("t4_count3", queue_full, 0); chk("t4_head", issue_rd_tag, 11);
    step(); issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg(); step();
    end
    neg(); chk("t4_empty", issue_valid, 0);

    // out-of-order select, order preserved after collapse
    step(); issue_ready = 1'b0;
    expect_issue(32'd1, 32'd2, 6'd21, 1'b0);
    expect_issue(32'd44, 32'd5, 6'd20, 1'b0);
    expect_issue(32'd3, 32'd4, 6'd22, 1'b0);
    disp(6'd4, 1'b0, 32'd0, 6'd0, 1'b1, 32'd5, 6'd20, 1'b0); step();
    disp(6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd21, 1'b0); step();
    disp(6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd22, 1'b0); step();
    disp_en = 1'b0;
    neg(); chk("t5_sel_b", issue_rd_tag, 21);
    step(); issue_ready = 1'b1;
    neg();
    step(); issue_ready = 1'b0; cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'd44;
    neg(); chk("t5_sel_wake", issue_rd_tag, BYP ? 64'd20 : 64'd22);
    step(); cdb_valid = 1'b0; issue_ready = 1'b1;
    neg(); chk("t5_a_first", issue_rd_tag, 20);
    step(); neg(); chk("t5_c_last", issue_rd_tag, 22);
    step(); neg(); chk("t5_empty", issue_valid, 0);

    // back-pressure hold
    step(); issue_ready = 1'b0;
    disp(6'd0, 1'b1, 32'd55, 6'd0, 1'b1, 32'd66, 6'd30, 1'b0);
    expect_issue(32'd55, 32'd66, 6'd30, 1'b0);
    step(); disp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t6_hold_v", issue_valid, 1);
      chk("t6_hold_rs1", issue_rs1_data, 55);
      chk("t6_hold_rd", issue_rd_tag, 30);
      step();
    end
    issue_ready = 1'b1;
    neg(); step(); issue_ready = 1'b0;

    // issue and dispatch in the same cycle
    disp(6'd0, 1'b1, 32'd61, 6'd0, 1'b1, 32'd62, 6'd31, 1'b0);
    expect_issue(32'd61, 32'd62, 6'd31, 1'b0);
    step();
    issue_ready = 1'b1;
    disp(6'd0, 1'b1, 32'd71, 6'd0, 1'b1, 32'd72, 6'd32, 1'b0);
    expect_issue(32'd71, 32'd72, 6'd32, 1'b0);
    neg(); step(); disp_en = 1'b0;
    neg(); chk("t7_tail", issue_rd_tag, 32);
    step(); neg(); chk("t7_empty", issue_valid, 0);

    // reset with a full queue
    step(); issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i), 6'(40 + i), 1'b0);
      step();
    end
    disp_en = 1'b0;
    neg(); chk("t8_full", queue_full, 1);
    step(); rst = 1'b1; issue_ready = 1'b1;
    neg(); chk("t8_rst_noissue", issue_valid, 0);
    step(); rst = 1'b0;
    neg();
    chk("t8_full_clr", queue_full, 0);
    chk("t8_valid_clr", issue_valid, 0);
    chk("t8_rs1_clr", issue_rs1_data, 0);

    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
